// File: rtl/au_incdec_pkg.sv
// Shared types and helpers for the au_incdec counter family.
// Latency: none (declarations only).
// Backpressure: not applicable.
// Contents: incdec_e direction encoding, adder architecture selectors, zext_step().
package au_incdec_pkg;

   typedef enum logic {AU_INC = 1'b0, AU_DEC = 1'b1} incdec_e;

   localparam int ARCH_RIPPLE = 0;
   localparam int ARCH_PREFIX = 1;

   // Zero-extends a step value: every bit at or above step_width is forced to 0,
   // so stray upper bits from a wider carrier can never leak into the sum.
   function automatic logic [63:0] zext_step(input logic [63:0] step_in,
                                             input int unsigned step_width);
      logic [63:0] mask;
      if (step_width >= 64)
         mask = '1;
      else
         mask = (64'd1 << step_width) - 64'd1;
      return step_in & mask;
   endfunction

endpackage

// File: rtl/au_incdec_counter_if.sv
// Control/data bundle between a counter user (master) and au_incdec_counter (slave).
// Latency: none (wires only).
// Backpressure: none; the counter accepts a command every cycle.
// Signals: load/load_val/en/inc_dec/step toward the counter; q/wrap/zero back.
interface au_incdec_counter_if #(
   parameter int WIDTH      = 8,
   parameter int STEP_WIDTH = 4
);
   logic                  load;
   logic [WIDTH-1:0]      load_val;
   logic                  en;
   logic                  inc_dec;
   logic [STEP_WIDTH-1:0] step;
   logic [WIDTH-1:0]      q;
   logic                  wrap;
   logic                  zero;

   modport master (
      output load, load_val, en, inc_dec, step,
      input  q, wrap, zero
   );

   modport slave (
      input  load, load_val, en, inc_dec, step,
      output q, wrap, zero
   );
endinterface

// File: rtl/au_incdec_step.sv
// Combinational a +/- zext(step) core with carry (inc) / borrow (dec) out.
// Latency: 0 cycles (pure combinational).
// Backpressure: not applicable.
// Ports: a (WIDTH), step (STEP_WIDTH), inc_dec -> s (WIDTH), c.
// ARCH selects a ripple chain or a Kogge-Stone prefix carry network; results are identical.
module au_incdec_step
   import au_incdec_pkg::*;
#(
   parameter int WIDTH      = 8,
   parameter int STEP_WIDTH = 4,
   parameter int ARCH       = ARCH_RIPPLE
) (
   input  logic [WIDTH-1:0]      a,
   input  logic [STEP_WIDTH-1:0] step,
   input  logic                  inc_dec,
   output logic [WIDTH-1:0]      s,
   output logic                  c
);

   logic [WIDTH-1:0] b_ext;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             cout;

   // Subtraction is a + ~b + 1; the adder's carry out is then the inverse of borrow.
   assign b_ext = WIDTH'(zext_step(64'(step), STEP_WIDTH));
   assign b     = (inc_dec == AU_DEC) ? ~b_ext : b_ext;
   assign cin   = (inc_dec == AU_DEC);
   assign c     = (inc_dec == AU_DEC) ? ~cout : cout;

   if (ARCH == ARCH_PREFIX) begin : g_prefix
      logic [WIDTH-1:0] g, p, gg, pp, gn, pn;
      logic [WIDTH:0]   cvec;

      always_comb begin
         g    = a & b;
         p    = a ^ b;
         // Fold carry-in into bit 0 so the prefix tree needs no extra column.
         g[0] = g[0] | (p[0] & cin);
         gg   = g;
         pp   = p;
         gn   = g;
         pn   = p;
         for (int d = 1; d < WIDTH; d = d * 2) begin
            gn = gg;
            pn = pp;
            for (int i = d; i < WIDTH; i++) begin
               gn[i] = gg[i] | (pp[i] & gg[i-d]);
               pn[i] = pp[i] & pp[i-d];
            end
            gg = gn;
            pp = pn;
         end
         cvec = {gg, cin};
         s    = p ^ cvec[WIDTH-1:0];
         cout = cvec[WIDTH];
      end
   end else begin : g_ripple
      logic cy;

      always_comb begin
         s  = '0;
         cy = cin;
         for (int i = 0; i < WIDTH; i++) begin
            s[i] = a[i] ^ b[i] ^ cy;
            cy   = (a[i] & b[i]) | (cy & (a[i] ^ b[i]));
         end
         cout = cy;
      end
   end

endmodule

// File: rtl/au_incdec_counter.sv
// Registered increment/decrement counter with load, variable step and wrap/saturate flag.
// Latency: 1 cycle; inputs sampled on the rising edge, q/wrap valid after it.
// Backpressure: none; a command is accepted every cycle (priority load > en > hold).
// Ports: clk, rst (async, active-high), bus (au_incdec_counter_if.slave).
// Build option: define AU_INCDEC_COUNTER_SAT_EN for saturating arithmetic (q clamps,
// wrap means "saturated"); default build wraps modulo 2^WIDTH.
module au_incdec_counter
   import au_incdec_pkg::*;
#(
   parameter int WIDTH      = 8,
   parameter int STEP_WIDTH = 4,
   parameter int ARCH       = ARCH_RIPPLE
) (
   input  logic                  clk,
   input  logic                  rst,
   au_incdec_counter_if.slave    bus
);

   logic [WIDTH-1:0] q_r;
   logic             wrap_r;
   logic [WIDTH-1:0] sum;
   logic             carry;
   logic [WIDTH-1:0] q_nxt;

   au_incdec_step #(
      .WIDTH      (WIDTH),
      .STEP_WIDTH (STEP_WIDTH),
      .ARCH       (ARCH)
   ) u_step (
      .a       (q_r),
      .step    (bus.step),
      .inc_dec (bus.inc_dec),
      .s       (sum),
      .c       (carry)
   );

`ifdef AU_INCDEC_COUNTER_SAT_EN
   // carry/borrow out means the true result left the range: pin to the limit crossed.
   assign q_nxt = !carry                   ? sum :
                  (bus.inc_dec == AU_DEC) ? '0  : '1;
`else
   assign q_nxt = sum;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q_r    <= '0;
         wrap_r <= 1'b0;
      end else if (bus.load) begin
         q_r    <= bus.load_val;
         wrap_r <= 1'b0;
      end else if (bus.en) begin
         q_r    <= q_nxt;
         wrap_r <= carry;
      end else begin
         wrap_r <= 1'b0;
      end
   end

   assign bus.q    = q_r;
   assign bus.wrap = wrap_r;
   assign bus.zero = (q_r == '0);

endmodule
